dvi_tx_scheduler: RTL and testbench
===================================

Name: dvi_tx_scheduler

Overview:
Sequences the 10-bit TMDS symbol stream into the three-channel serializer stage (red/green/blue symbol inputs, one symbol per parallel clock). Owns video timing (h/v counters, sync, data enable), the link start-up sequence, and per-cycle selection between fixed control tokens and upstream encoded pixel symbols. Runs in the parallel (pixel) clock domain, between the pixel source/TMDS encoder and the serializer.

Parameters:
H_ACTIVE, 640, active pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, hsync width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_ACTIVE, 480, active lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
HSYNC_POL, 0, hsync level during sync pulse; idle level is ~HSYNC_POL
VSYNC_POL, 0, vsync level during sync pulse; idle level is ~VSYNC_POL
WARMUP_FRAMES, 2, full frames of control-only output before video is enabled (>=1)
UNDERFLOW_SYMBOL, 10'h100, symbol substituted on all channels when pixel data is missing

Ports:
clk_i  in  1  parallel/pixel clock
reset_n_i  in  1  asynchronous active-low reset
enable_i  in  1  level; request to run the link
pixel_req_o  out  1  upstream must supply a pixel's symbols in the next cycle
pixel_valid_i  in  1  symbols on symbol_*_i valid, sampled one cycle after pixel_req_o
symbol_red_i  in  10  encoded red symbol
symbol_green_i  in  10  encoded green symbol
symbol_blue_i  in  10  encoded blue symbol
symbol_red_o  out  10  to serializer, bit 0 transmitted first
symbol_green_o  out  10  to serializer
symbol_blue_o  out  10  to serializer
de_o  out  1  data enable aligned with symbol_*_o
frame_start_o  out  1  one-cycle pulse at h=0,v=0 (counter stage)
running_o  out  1  high in ACTIVE state
underflow_o  out  1  sticky underflow flag

Behaviour:
- Clock and reset: one clock (clk_i); asynchronous active-low reset (reset_n_i).
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL analogous. h_cnt counts 0..H_TOTAL-1 and wraps. v_cnt increments on h wrap and wraps at V_TOTAL-1. Counter widths are sized by $clog2 of the totals.
- Regions: active = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE. hsync is in pulse for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC. vsync is analogous on v_cnt.
- Control tokens, written as [9:0]: C=00 -> 10'h354; 01 -> 10'h0AB; 10 -> 10'h154; 11 -> 10'h2AB. Blue carries {c1,c0}={vsync,hsync} (polarity already applied). Red and green always carry 00.
- States:
  - IDLE: counters held at 0. All outputs show token 10'h354, de_o=0. Goes to WARMUP when enable_i=1.
  - WARMUP: counters run, de_o=0, blue carries syncs. Counts frames on frame_start. Goes to ACTIVE at the frame_start that completes WARMUP_FRAMES full frames, so video begins exactly at h=0,v=0.
  - ACTIVE: normal video.
  - enable_i=0 in WARMUP or ACTIVE: the current frame completes, then the block goes to IDLE at the next h=0,v=0. enable_i reasserted before then cancels the stop.
- Pipeline, 3 stages:
  - Stage 0: counters. pixel_req_o = (state==ACTIVE) && active (combinational from registers). frame_start_o pulses at stage 0.
  - Stage 1: upstream presents symbols. Registered copies of active, hsync and vsync are carried along.
  - Stage 2: registered symbol_*_o and de_o.
  - Net timing: pixel_req_o at cycle t -> that pixel appears on symbol_*_o and de_o=1 from cycle t+2. Sync tokens are delayed by the same 2 cycles.
- Underflow: if stage 1 holds a request and pixel_valid_i=0, stage 2 outputs UNDERFLOW_SYMBOL on all three channels with de_o=1, and underflow_o is set. underflow_o clears only on reset or on entry to IDLE. pixel_valid_i is ignored when no request is pending.
- Reset values: symbol_*_o=10'h354, de_o=0, pixel_req_o=0, frame_start_o=0, running_o=0, underflow_o=0, state=IDLE, counters=0.
- Reset mid-frame: immediate return to reset values. There is no partial-frame completion.

Test Plan:
- Reset, enable_i=0 for 100 cycles -> all symbol_*_o=10'h354, de_o=0, pixel_req_o never asserted.
- enable_i=1 with WARMUP_FRAMES=2, small timing (H 8/2/2/2, V 4/1/1/1) -> no pixel_req_o for 2 frames. First pixel_req_o coincides with the 3rd frame_start_o, and de_o rises exactly 2 cycles later.
- ACTIVE with incrementing symbols, pixel_valid_i=1 -> symbol_*_o equals the input 1 cycle after each sample. Blue carries 10'h2AB when both syncs are in pulse with POL=1 and 10'h354 when neither is. Red and green are always 10'h354 outside active.
- pixel_valid_i=0 for one requested pixel -> that slot outputs 10'h100 on all channels with de_o=1, and underflow_o stays 1 thereafter until IDLE.
- enable_i dropped mid-frame -> the frame finishes normally, the block enters IDLE at the next h=0,v=0, and running_o and underflow_o go to 0.
- reset_n_i asserted mid-line asynchronously -> outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/dvi_tx_scheduler.sv
// dvi_tx_scheduler: video timing, link start-up sequencing and per-cycle
// selection between control tokens and upstream pixel symbols for the
// three TMDS channels feeding the serializer.
//
// Pixel handshake: pixel_req_o high in cycle t means stage 0 holds an active
// pixel; upstream drives symbol_*_i with pixel_valid_i=1 during cycle t+1,
// and they are captured at the edge ending t+1. If pixel_valid_i is low in
// that cycle the slot is filled with UNDERFLOW_SYMBOL and underflow_o is set.
// pixel_valid_i and symbol_*_i are don't-care in cycles with no request.
module dvi_tx_scheduler #(
    parameter int         H_ACTIVE         = 640,
    parameter int         H_FP             = 16,
    parameter int         H_SYNC           = 96,
    parameter int         H_BP             = 48,
    parameter int         V_ACTIVE         = 480,
    parameter int         V_FP             = 10,
    parameter int         V_SYNC           = 2,
    parameter int         V_BP             = 33,
    parameter logic       HSYNC_POL        = 1'b0,
    parameter logic       VSYNC_POL        = 1'b0,
    parameter int         WARMUP_FRAMES    = 2,
    parameter logic [9:0] UNDERFLOW_SYMBOL = 10'h100
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic       enable_i,
    output logic       pixel_req_o,
    input  logic       pixel_valid_i,
    input  logic [9:0] symbol_red_i,
    input  logic [9:0] symbol_green_i,
    input  logic [9:0] symbol_blue_i,
    output logic [9:0] symbol_red_o,
    output logic [9:0] symbol_green_o,
    output logic [9:0] symbol_blue_o,
    output logic       de_o,
    output logic       frame_start_o,
    output logic       running_o,
    output logic       underflow_o
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam int FW = (WARMUP_FRAMES > 1) ? $clog2(WARMUP_FRAMES) : 1;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    // Region bounds are one bit wider so an end bound equal to the total fits.
    localparam logic [HW:0]   H_ACT_END = (HW+1)'(H_ACTIVE);
    localparam logic [HW:0]   HS_BEGIN  = (HW+1)'(H_ACTIVE + H_FP);
    localparam logic [HW:0]   HS_END    = (HW+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW:0]   V_ACT_END = (VW+1)'(V_ACTIVE);
    localparam logic [VW:0]   VS_BEGIN  = (VW+1)'(V_ACTIVE + V_FP);
    localparam logic [VW:0]   VS_END    = (VW+1)'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [FW-1:0] WU_LAST   = FW'(WARMUP_FRAMES - 1);

    localparam logic [9:0] CTL_00 = 10'h354;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic [FW-1:0] frm_cnt;

    logic h_last, v_last, frame_end;
    logic active, hs_pulse, vs_pulse, hs_lvl, vs_lvl;

    logic s1_req, s1_run, s1_hs, s1_vs;

    function automatic logic [9:0] ctl_token(input logic [1:0] c);
        case (c)
            2'b00:   return 10'h354;
            2'b01:   return 10'h0AB;
            2'b10:   return 10'h154;
            default: return 10'h2AB;
        endcase
    endfunction

    // Stage 0 decode: regions, sync levels and the upstream request.
    always_comb begin
        h_last        = (h_cnt == H_LAST);
        v_last        = (v_cnt == V_LAST);
        frame_end     = h_last && v_last;
        active        = ({1'b0, h_cnt} < H_ACT_END) && ({1'b0, v_cnt} < V_ACT_END);
        hs_pulse      = ({1'b0, h_cnt} >= HS_BEGIN) && ({1'b0, h_cnt} < HS_END);
        vs_pulse      = ({1'b0, v_cnt} >= VS_BEGIN) && ({1'b0, v_cnt} < VS_END);
        hs_lvl        = hs_pulse ? HSYNC_POL : ~HSYNC_POL;
        vs_lvl        = vs_pulse ? VSYNC_POL : ~VSYNC_POL;
        pixel_req_o   = (state_q == ACTIVE) && active;
        frame_start_o = (state_q != IDLE) && (h_cnt == '0) && (v_cnt == '0);
        running_o     = (state_q == ACTIVE);
    end

    // Link state transitions only happen at a frame boundary once running, so
    // video always begins and ends on whole frames.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (enable_i) state_d = WARMUP;
            end
            WARMUP: begin
                if (frame_end) begin
                    if (!enable_i)              state_d = IDLE;
                    else if (frm_cnt == WU_LAST) state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (frame_end && !enable_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register and warm-up frame counter.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            frm_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (state_q != WARMUP) frm_cnt <= '0;
            else if (frame_end)    frm_cnt <= frm_cnt + 1'b1;
        end
    end

    // Raster counters: held at the origin while idle, free-running otherwise.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (state_q == IDLE) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    // Stage 1: carry request and sync levels while upstream fetches symbols.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            s1_req <= 1'b0;
            s1_run <= 1'b0;
            s1_hs  <= 1'b0;
            s1_vs  <= 1'b0;
        end else begin
            s1_req <= pixel_req_o;
            s1_run <= (state_q != IDLE);
            s1_hs  <= hs_lvl;
            s1_vs  <= vs_lvl;
        end
    end

    // Stage 2: select pixel, underflow filler or control token per cycle.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            symbol_red_o   <= CTL_00;
            symbol_green_o <= CTL_00;
            symbol_blue_o  <= CTL_00;
            de_o           <= 1'b0;
        end else if (!s1_run) begin
            symbol_red_o   <= CTL_00;
            symbol_green_o <= CTL_00;
            symbol_blue_o  <= CTL_00;
            de_o           <= 1'b0;
        end else if (s1_req) begin
            de_o           <= 1'b1;
            symbol_red_o   <= pixel_valid_i ? symbol_red_i   : UNDERFLOW_SYMBOL;
            symbol_green_o <= pixel_valid_i ? symbol_green_i : UNDERFLOW_SYMBOL;
            symbol_blue_o  <= pixel_valid_i ? symbol_blue_i  : UNDERFLOW_SYMBOL;
        end else begin
            de_o           <= 1'b0;
            symbol_red_o   <= CTL_00;
            symbol_green_o <= CTL_00;
            symbol_blue_o  <= ctl_token({s1_vs, s1_hs});
        end
    end

    // Sticky underflow flag, cleared when the link drops back to idle.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)                    underflow_o <= 1'b0;
        else if (state_d == IDLE)          underflow_o <= 1'b0;
        else if (s1_req && !pixel_valid_i) underflow_o <= 1'b1;
    end

endmodule

// File: tb/tb_dvi_tx_scheduler.sv
// tb_dvi_tx_scheduler: directed bench for dvi_tx_scheduler on a small raster
// (H 8/2/2/2 = 14 clocks, V 4/1/1/1 = 7 lines, 98 clocks per frame).
module tb_dvi_tx_scheduler;
    localparam int         H_TOT = 14;
    localparam int         FRAME = 98;
    localparam logic [9:0] CTL_00 = 10'h354;
    localparam logic [9:0] UF_SYM = 10'h100;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       enable;
    logic       pixel_valid;
    logic [9:0] sym_r_in, sym_g_in, sym_b_in;
    logic       pixel_req, de, frame_start, running, underflow;
    logic [9:0] sym_r, sym_g, sym_b;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int pix_idx = 0;

    logic [30:0] exp_q[$];
    logic        exp_uf     = 1'b0;
    logic        uf_pending = 1'b0;
    logic        req_d      = 1'b0;

    dvi_tx_scheduler #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1),
        .WARMUP_FRAMES(2), .UNDERFLOW_SYMBOL(10'h100)
    ) dut (
        .clk_i(clk),
        .reset_n_i(reset_n),
        .enable_i(enable),
        .pixel_req_o(pixel_req),
        .pixel_valid_i(pixel_valid),
        .symbol_red_i(sym_r_in),
        .symbol_green_i(sym_g_in),
        .symbol_blue_i(sym_b_in),
        .symbol_red_o(sym_r),
        .symbol_green_o(sym_g),
        .symbol_blue_o(sym_b),
        .de_o(de),
        .frame_start_o(frame_start),
        .running_o(running),
        .underflow_o(underflow)
    );

    // Clock and cycle index (cyc read at a negedge names the current cycle).
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Upstream pixel source: answers each request in the following cycle and
    // pushes the symbols the serializer must later show.
    always @(negedge clk) req_d = pixel_req;
    always @(posedge clk) begin
        #1;
        if (req_d) begin
            if (uf_pending) begin
                uf_pending  = 1'b0;
                exp_uf      = 1'b1;
                pixel_valid = 1'b0;
                sym_r_in    = 10'($urandom_range(0, 1023));
                sym_g_in    = 10'($urandom_range(0, 1023));
                sym_b_in    = 10'($urandom_range(0, 1023));
                exp_q.push_back({1'b1, UF_SYM, UF_SYM, UF_SYM});
            end else begin
                pixel_valid = 1'b1;
                sym_r_in    = 10'(pix_idx * 3 + 1);
                sym_g_in    = 10'h3FF - 10'(pix_idx);
                sym_b_in    = 10'(pix_idx * 4);
                exp_q.push_back({exp_uf, sym_r_in, sym_g_in, sym_b_in});
                pix_idx++;
            end
        end else begin
            pixel_valid = 1'($urandom_range(0, 1));
            sym_r_in    = 10'($urandom_range(0, 1023));
            sym_g_in    = 10'($urandom_range(0, 1023));
            sym_b_in    = 10'($urandom_range(0, 1023));
        end
    end

    // Monitor: every data-enable slot must match the oldest expected pixel.
    always @(negedge clk) begin
        logic [30:0] e;
        if (reset_n === 1'b1 && de === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL pixel_slot: got de_o=1 %h/%h/%h expected no pixel", sym_r, sym_g, sym_b);
            end else begin
                e = exp_q.pop_front();
                if ({underflow, sym_r, sym_g, sym_b} !== e) begin
                    n_err++;
                    $display("FAIL pixel_slot: got uf=%b %h/%h/%h expected uf=%b %h/%h/%h",
                             underflow, sym_r, sym_g, sym_b, e[30], e[29:20], e[19:10], e[9:0]);
                end
            end
        end
    end

    task automatic wait_fs(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            if (frame_start) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL frame_start_wait: got no pulse expected one within %0d cycles", 2 * FRAME);
        end
    endtask

    // Check the control tokens emitted for raster position (h, v).
    task automatic check_token(input string name, input int h, input int v, input logic [9:0] exp_blue);
        bit ok;
        wait_fs(ok);
        if (ok) begin
            repeat (v * H_TOT + h + 2) @(posedge clk);
            @(negedge clk);
            chk(name, {de, sym_r, sym_g, sym_b}, {1'b0, CTL_00, CTL_00, exp_blue});
        end
    endtask

    initial begin
        int  e_cyc, fs_n, fs1, fs2, fs3, first_req, first_de;
        logic run_fs2;
        bit  ok;

        reset_n = 1'b0; enable = 1'b0; pixel_valid = 1'b0;
        sym_r_in = '0; sym_g_in = '0; sym_b_in = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_out", {de, pixel_req, frame_start, running, underflow, sym_r, sym_g, sym_b},
            {5'b0, CTL_00, CTL_00, CTL_00});
        reset_n = 1'b1;

        // Idle with enable low
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("idle_out", {de, pixel_req, frame_start, running, sym_r, sym_g, sym_b},
                {4'b0, CTL_00, CTL_00, CTL_00});
        end

        // Warm-up: two control-only frames, video begins on the third frame start
        enable = 1'b1;
        e_cyc = cyc;
        fs_n = 0; fs1 = -1; fs2 = -1; fs3 = -1; first_req = -1; first_de = -1;
        run_fs2 = 1'bx;
        for (int i = 0; i < 4 * FRAME; i++) begin
            @(negedge clk);
            if (frame_start) begin
                fs_n++;
                if (fs_n == 1) fs1 = cyc;
                if (fs_n == 2) begin fs2 = cyc; run_fs2 = running; end
                if (fs_n == 3) fs3 = cyc;
            end
            if (pixel_req && first_req < 0) first_req = cyc;
            if (de) begin
                first_de = cyc;
                break;
            end
        end
        chk("fs1_cycle", fs1, e_cyc + 1);
        chk("fs2_cycle", fs2, e_cyc + 1 + FRAME);
        chk("running_in_warmup", run_fs2, 1'b0);
        chk("fs3_cycle", fs3, e_cyc + 1 + 2 * FRAME);
        chk("first_req_cycle", first_req, e_cyc + 1 + 2 * FRAME);
        chk("first_de_cycle", first_de, e_cyc + 3 + 2 * FRAME);

        // One starved pixel in the next frame, then sync token positions
        uf_pending = 1'b1;
        check_token("tok_front_porch", 8, 0, 10'h354);
        check_token("tok_hsync", 10, 0, 10'h0AB);
        check_token("tok_both_sync", 11, 5, 10'h2AB);
        check_token("tok_vsync", 2, 5, 10'h154);
        chk("underflow_sticky", underflow, 1'b1);

        // Enable glitch inside a frame is cancelled before the frame ends
        wait_fs(ok);
        repeat (20) @(negedge clk);
        enable = 1'b0;
        repeat (10) @(negedge clk);
        enable = 1'b1;
        wait_fs(ok);
        chk("stop_cancelled", running, 1'b1);

        // Enable dropped mid-frame: frame completes, idle at the next origin
        repeat (20) @(negedge clk);
        enable = 1'b0;
        repeat (77) @(negedge clk);
        chk("last_cycle_running", {running, underflow}, 2'b11);
        @(negedge clk);
        exp_uf = 1'b0;
        chk("idle_entry", {running, underflow, frame_start, pixel_req}, 4'b0000);
        repeat (2) @(negedge clk);
        chk("idle_tokens", {de, sym_r, sym_g, sym_b}, {1'b0, CTL_00, CTL_00, CTL_00});
        chk("queue_drained", exp_q.size(), 0);

        // Asynchronous reset while a pixel is on the outputs
        enable = 1'b1;
        uf_pending = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 4 * FRAME; i++) begin
            @(negedge clk);
            if (de) begin
                ok = 1'b1;
                break;
            end
        end
        chk("rerun_de_seen", ok, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset_out", {de, pixel_req, frame_start, running, underflow, sym_r, sym_g, sym_b},
            {5'b0, CTL_00, CTL_00, CTL_00});
        enable = 1'b0;
        exp_uf = 1'b0;
        uf_pending = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        exp_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_reset_idle", {de, pixel_req, running, underflow, sym_r, sym_g, sym_b},
            {4'b0, CTL_00, CTL_00, CTL_00});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
